// File: rtl/triple_loader.sv
// Collects a serial operand stream into (a, b, c) triples for a largest-of-three stage.
// A full triple is held stable until it is consumed; flush drops a partial triple only.
module triple_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [15:0]      triple_count,
    output logic             partial_drop
);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      triple_count_q, triple_count_d;
    logic             partial_drop_q, partial_drop_d;

    // Flush masks acceptance in the FILL states; in HOLD only downstream consumption frees a slot.
    assign in_ready = (state_q == HOLD) ? out_ready : ~flush;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        triple_count_d = triple_count_q;
        partial_drop_d = 1'b0;

        unique case (state_q)
            FILL0: begin
                if (!flush && in_valid) begin
                    a_d     = in_data;
                    state_d = FILL1;
                end
            end
            FILL1: begin
                if (flush) begin
                    state_d        = FILL0;
                    partial_drop_d = 1'b1;
                end else if (in_valid) begin
                    b_d     = in_data;
                    state_d = FILL2;
                end
            end
            FILL2: begin
                if (flush) begin
                    state_d        = FILL0;
                    partial_drop_d = 1'b1;
                end else if (in_valid) begin
                    c_d     = in_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (triple_count_q != 16'hFFFF) begin
                        triple_count_d = triple_count_q + 16'd1;
                    end
                    // A byte offered on the consume edge starts the next triple with no bubble.
                    if (in_valid) begin
                        a_d     = in_data;
                        state_d = FILL1;
                    end else begin
                        state_d = FILL0;
                    end
                end
            end
            default: state_d = FILL0;
        endcase

        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL0;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            out_valid_q    <= 1'b0;
            triple_count_q <= '0;
            partial_drop_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            c_q            <= c_d;
            out_valid_q    <= out_valid_d;
            triple_count_q <= triple_count_d;
            partial_drop_q <= partial_drop_d;
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign c            = c_q;
    assign out_valid    = out_valid_q;
    assign triple_count = triple_count_q;
    assign partial_drop = partial_drop_q;

endmodule

// File: tb/tb_triple_loader.sv
// Directed bench for triple_loader: one task per scenario, inline comparisons.
module tb_triple_loader;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [15:0]      triple_count;
    logic             partial_drop;

    int n_cmp = 0;
    int n_mis = 0;
    logic rdy_seen;

    triple_loader #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a            (a),
        .b            (b),
        .c            (c),
        .triple_count (triple_count),
        .partial_drop (partial_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at the falling edge, sample in_ready before the rising edge, settle 1 after it.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_seen = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, a, b, c, triple_count, partial_drop} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got ov=%0b a=%0d b=%0d c=%0d cnt=%0d pd=%0b, want all 0",
                     out_valid, a, b, c, triple_count, partial_drop);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        cycle(1, 8'd10, 1, 0);
        cycle(1, 8'd25, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++; $display("FAIL basic_early_valid: got %0b want 0", out_valid);
        end
        cycle(1, 8'd15, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || a !== 8'd10 || b !== 8'd25 || c !== 8'd15) begin
            n_mis++;
            $display("FAIL basic_triple: got ov=%0b a=%0d b=%0d c=%0d want 1 10 25 15", out_valid, a, b, c);
        end
        begin
            logic [WIDTH-1:0] mx;
            mx = (a > b) ? a : b;
            mx = (c > mx) ? c : mx;
            n_cmp++;
            if (mx !== 8'd25) begin
                n_mis++; $display("FAIL basic_max: got %0d want 25", mx);
            end
        end
        cycle(0, 8'd0, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || triple_count !== 16'd1) begin
            n_mis++;
            $display("FAIL basic_consume: got ov=%0b cnt=%0d want 0 1", out_valid, triple_count);
        end
    endtask

    task automatic test_backpressure();
        cycle(1, 8'd50, 0, 0);
        cycle(1, 8'd20, 0, 0);
        cycle(1, 8'd30, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'd99, 0, 0);
            n_cmp++;
            if (rdy_seen !== 1'b0 || out_valid !== 1'b1 || a !== 8'd50 || b !== 8'd20 || c !== 8'd30
                || triple_count !== 16'd1) begin
                n_mis++;
                $display("FAIL backpressure_hold[%0d]: got rdy=%0b ov=%0b a=%0d b=%0d c=%0d cnt=%0d want 0 1 50 20 30 1",
                         i, rdy_seen, out_valid, a, b, c, triple_count);
            end
        end
        cycle(0, 8'd0, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || triple_count !== 16'd2) begin
            n_mis++;
            $display("FAIL backpressure_release: got ov=%0b cnt=%0d want 0 2", out_valid, triple_count);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 8'd5, 1, 0);
        cycle(1, 8'd5, 1, 0);
        cycle(1, 8'd5, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || a !== 8'd5 || b !== 8'd5 || c !== 8'd5) begin
            n_mis++;
            $display("FAIL b2b_first: got ov=%0b a=%0d b=%0d c=%0d want 1 5 5 5", out_valid, a, b, c);
        end
        cycle(1, 8'd7, 1, 0);
        n_cmp++;
        if (rdy_seen !== 1'b1 || out_valid !== 1'b0 || a !== 8'd7 || triple_count !== 16'd3) begin
            n_mis++;
            $display("FAIL b2b_consume_edge: got rdy=%0b ov=%0b a=%0d cnt=%0d want 1 0 7 3",
                     rdy_seen, out_valid, a, triple_count);
        end
        cycle(1, 8'd7, 1, 0);
        cycle(1, 8'd9, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || a !== 8'd7 || b !== 8'd7 || c !== 8'd9) begin
            n_mis++;
            $display("FAIL b2b_second: got ov=%0b a=%0d b=%0d c=%0d want 1 7 7 9", out_valid, a, b, c);
        end
        cycle(0, 8'd0, 1, 0);
        n_cmp++;
        if (triple_count !== 16'd4) begin
            n_mis++; $display("FAIL b2b_count: got %0d want 4", triple_count);
        end
    endtask

    task automatic test_flush();
        cycle(0, 8'd0, 1, 1);
        n_cmp++;
        if (partial_drop !== 1'b0 || rdy_seen !== 1'b0) begin
            n_mis++;
            $display("FAIL flush_fill0: got pd=%0b rdy=%0b want 0 0", partial_drop, rdy_seen);
        end
        cycle(1, 8'd1, 1, 0);
        cycle(1, 8'd2, 1, 0);
        cycle(1, 8'd3, 1, 1);
        n_cmp++;
        if (rdy_seen !== 1'b0 || partial_drop !== 1'b1 || out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL flush_drop: got rdy=%0b pd=%0b ov=%0b want 0 1 0", rdy_seen, partial_drop, out_valid);
        end
        cycle(1, 8'd4, 1, 0);
        n_cmp++;
        if (partial_drop !== 1'b0) begin
            n_mis++; $display("FAIL flush_pulse_width: got pd=%0b want 0", partial_drop);
        end
        cycle(1, 8'd5, 1, 0);
        cycle(1, 8'd6, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || a !== 8'd4 || b !== 8'd5 || c !== 8'd6) begin
            n_mis++;
            $display("FAIL flush_refill: got ov=%0b a=%0d b=%0d c=%0d want 1 4 5 6", out_valid, a, b, c);
        end
        cycle(0, 8'd0, 1, 0);
        n_cmp++;
        if (triple_count !== 16'd5) begin
            n_mis++; $display("FAIL flush_count: got %0d want 5", triple_count);
        end
    endtask

    task automatic test_flush_hold();
        cycle(1, 8'd11, 0, 0);
        cycle(1, 8'd12, 0, 0);
        cycle(1, 8'd13, 0, 0);
        cycle(0, 8'd0, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b1 || partial_drop !== 1'b0 || a !== 8'd11 || b !== 8'd12 || c !== 8'd13) begin
            n_mis++;
            $display("FAIL flush_hold: got ov=%0b pd=%0b a=%0d b=%0d c=%0d want 1 0 11 12 13",
                     out_valid, partial_drop, a, b, c);
        end
        cycle(0, 8'd0, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || triple_count !== 16'd6) begin
            n_mis++;
            $display("FAIL flush_hold_consume: got ov=%0b cnt=%0d want 0 6", out_valid, triple_count);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 8'd41, 1, 0);
        cycle(1, 8'd42, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, a, b, c, triple_count, partial_drop} !== '0) begin
            n_mis++;
            $display("FAIL async_reset: got ov=%0b a=%0d b=%0d c=%0d cnt=%0d pd=%0b want all 0",
                     out_valid, a, b, c, triple_count, partial_drop);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || partial_drop !== 1'b0) begin
            n_mis++;
            $display("FAIL async_reset_after: got rdy=%0b pd=%0b want 1 0", in_ready, partial_drop);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.triple_count_q = 16'hFFFE;
        #1;
        release dut.triple_count_q;
        for (int t = 0; t < 2; t++) begin
            cycle(1, 8'd1, 1, 0);
            cycle(1, 8'd2, 1, 0);
            cycle(1, 8'd3, 1, 0);
            cycle(0, 8'd0, 1, 0);
            n_cmp++;
            if (triple_count !== 16'hFFFF) begin
                n_mis++;
                $display("FAIL saturation[%0d]: got %h want ffff", t, triple_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_flush_hold();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
